// File: rtl/cim_tile_model.sv
// Compute-in-memory tile behavioural model.
// The tile holds an input vector and a weight crossbar. A start request
// computes one output column at a time: xbar_size multiply-accumulate
// cycles, then one cycle that stores the shifted and saturated result
// into the output buffer. The output buffer is readable at any time
// through a registered read port.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_start; input and weight writes are accepted
// MAC   | accumulating in[r]*w[r][c] for the current column, one row per cycle
// STORE | writing the saturated column result to obuf, then next column or IDLE

module cim_tile_model #(
    parameter int xbar_size     = 512,
    parameter int datatype_size = 8,
    parameter int out_shift     = datatype_size,
    localparam int n_out = xbar_size / datatype_size,
    localparam int acc_w = 2 * datatype_size + $clog2(xbar_size),
    localparam int row_w = $clog2(xbar_size),
    localparam int col_w = $clog2(n_out)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_w_we,
    input  logic [row_w-1:0]         i_w_row,
    input  logic [col_w-1:0]         i_w_col,
    input  logic [datatype_size-1:0] i_w_data,

    input  logic                     i_wr_en,
    input  logic [row_w-1:0]         i_wr_addr,
    input  logic [datatype_size-1:0] i_wr_data,

    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,

    input  logic [row_w-1:0]         i_rd_addr,
    output logic [datatype_size-1:0] o_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam logic [datatype_size-1:0] data_max = {datatype_size{1'b1}};

    state_t state_q;
    state_t state_d;

    logic [row_w-1:0]         row_q;
    logic [col_w-1:0]         col_q;
    logic [acc_w-1:0]         acc_q;
    logic                     done_q;
    logic [datatype_size-1:0] rd_data_q;

    logic [datatype_size-1:0] in_mem [xbar_size];
    logic [datatype_size-1:0] w_mem  [xbar_size][n_out];
    logic [datatype_size-1:0] obuf   [n_out];

    logic                         last_row;
    logic                         last_col;
    logic                         can_write;
    logic [2*datatype_size-1:0]   prod;
    logic [acc_w-1:0]             acc_shifted;
    logic [datatype_size-1:0]     acc_sat;

    // Shared decode: end-of-loop flags, write gating, MAC product and result saturation.
    always_comb begin
        last_row    = (row_q == row_w'(xbar_size - 1));
        last_col    = (col_q == col_w'(n_out - 1));
        // Busy is a registered function of state, so IDLE is exactly "not busy".
        can_write   = (state_q == IDLE) && !rst;
        prod        = {{datatype_size{1'b0}}, in_mem[row_q]} *
                      {{datatype_size{1'b0}}, w_mem[row_q][col_q]};
        acc_shifted = acc_q >> out_shift;
        if (acc_shifted > acc_w'(data_max)) begin
            acc_sat = data_max;
        end else begin
            acc_sat = acc_shifted[datatype_size-1:0];
        end
    end

    // State register; reset wins over everything, including i_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. i_start is only looked at in IDLE, so a start while
    // busy is simply ignored rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_row) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                if (last_col) begin
                    state_d = IDLE;
                end else begin
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row/column counters and accumulator; held at zero while idle so a new
    // run always starts from row 0, column 0 with an empty accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            acc_q <= '0;
        end else begin
            case (state_q)
                MAC: begin
                    acc_q <= acc_q + acc_w'(prod);
                    if (last_row) begin
                        row_q <= '0;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                STORE: begin
                    acc_q <= '0;
                    row_q <= '0;
                    if (!last_col) begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: begin
                    row_q <= '0;
                    col_q <= '0;
                    acc_q <= '0;
                end
            endcase
        end
    end

    // Input buffer writes; contents survive reset so an aborted run can be redone.
    always_ff @(posedge clk) begin
        if (can_write && i_wr_en) begin
            in_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Weight writes; column addresses beyond the crossbar are discarded.
    always_ff @(posedge clk) begin
        if (can_write && i_w_we && (int'(i_w_col) < n_out)) begin
            w_mem[i_w_row][i_w_col] <= i_w_data;
        end
    end

    // Output buffer: cleared on reset, one column written per STORE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < n_out; i++) begin
                obuf[i] <= '0;
            end
        end else if (state_q == STORE) begin
            obuf[col_q] <= acc_sat;
        end
    end

    // Registered read port. It samples obuf before the same-edge STORE update,
    // so a read colliding with a store returns the old column value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (int'(i_rd_addr) < n_out) begin
            rd_data_q <= obuf[i_rd_addr[col_w-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    // Completion pulse lands in the first cycle back in IDLE after the last STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == STORE) && last_col;
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_cim_tile_model.sv
// Bench for cim_tile_model with xbar_size=8, datatype_size=4.
// Two instances share all inputs: one with out_shift=0, one with out_shift=2.
// Expected outputs come from a dot-product model over plain integer arrays.

module tb_cim_tile_model;

    localparam int xs = 8;
    localparam int ds = 4;
    localparam int no = 2;

    logic       clk;
    logic       rst;
    logic       i_w_we;
    logic [2:0] i_w_row;
    logic       i_w_col;
    logic [3:0] i_w_data;
    logic       i_wr_en;
    logic [2:0] i_wr_addr;
    logic [3:0] i_wr_data;
    logic       i_start;
    logic [2:0] i_rd_addr;

    logic       busy0, done0, busy2, done2;
    logic [3:0] rd0, rd2;

    int checks = 0;
    int errors = 0;

    int in_m [xs];
    int w_m  [xs][no];
    int ob_m [2][no];   // [0]: shift 0 instance, [1]: shift 2 instance

    cim_tile_model #(.xbar_size(xs), .datatype_size(ds), .out_shift(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .o_busy(busy0), .o_done(done0),
        .i_rd_addr(i_rd_addr), .o_rd_data(rd0)
    );

    cim_tile_model #(.xbar_size(xs), .datatype_size(ds), .out_shift(2)) dut2 (
        .clk(clk), .rst(rst),
        .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .o_busy(busy2), .o_done(done2),
        .i_rd_addr(i_rd_addr), .o_rd_data(rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Column result: dot product of input vector and weight column, shifted, clamped to 15.
    function automatic int model_out(input int c, input int sh);
        int sum = 0;
        for (int r = 0; r < xs; r++) sum += in_m[r] * w_m[r][c];
        sum = sum >> sh;
        return (sum > 15) ? 15 : sum;
    endfunction

    task automatic write_in(input int a, input int d);
        i_wr_en = 1'b1; i_wr_addr = 3'(a); i_wr_data = 4'(d);
        tick();
        i_wr_en = 1'b0;
        in_m[a] = d;
    endtask

    task automatic write_w(input int r, input int c, input int d);
        i_w_we = 1'b1; i_w_row = 3'(r); i_w_col = 1'(c); i_w_data = 4'(d);
        tick();
        i_w_we = 1'b0;
        w_m[r][c] = d;
    endtask

    task automatic read_check(input int a);
        int e0, e2;
        i_rd_addr = 3'(a);
        tick();
        e0 = (a < no) ? ob_m[0][a] : 0;
        e2 = (a < no) ? ob_m[1][a] : 0;
        check($sformatf("rd_s0_addr%0d", a), rd0, e0);
        check($sformatf("rd_s2_addr%0d", a), rd2, e2);
    endtask

    // One compute run. inj_at: busy cycle at which start and both writes are
    // driven (0 = never). rst_at: busy cycle at which reset is driven (0 = never).
    // pre_in0/pre_w00: values written to in[0]/w[0][0] in the start cycle (-1 = none).
    task automatic run(input int inj_at, input int rst_at, input int pre_in0, input int pre_w00);
        int cnt;
        int old0, old2;
        int nv [2][no];
        logic inj;
        if (pre_in0 >= 0) begin
            i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 4'(pre_in0);
            in_m[0] = pre_in0;
        end
        if (pre_w00 >= 0) begin
            i_w_we = 1'b1; i_w_row = 3'd0; i_w_col = 1'b0; i_w_data = 4'(pre_w00);
            w_m[0][0] = pre_w00;
        end
        for (int c = 0; c < no; c++) begin
            nv[0][c] = model_out(c, 0);
            nv[1][c] = model_out(c, 2);
        end
        old0 = ob_m[0][0];
        old2 = ob_m[1][0];
        i_start = 1'b1;
        i_rd_addr = 3'd0;
        tick();
        i_start = 1'b0; i_wr_en = 1'b0; i_w_we = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 100) begin
            cnt++;
            check("done_low_while_busy", done0, 0);
            check("busy_s2_tracks", busy2, 1);
            if (cnt == 6) begin
                check("rd_busy_old_s0", rd0, old0);
                check("rd_busy_old_s2", rd2, old2);
            end
            if (cnt == 10 && rst_at == 0) begin
                check("rd_store_collide_s0", rd0, old0);
                check("rd_store_collide_s2", rd2, old2);
            end
            if (cnt == 11 && rst_at == 0) begin
                check("rd_after_store_s0", rd0, nv[0][0]);
                check("rd_after_store_s2", rd2, nv[1][0]);
            end
            inj = (cnt == inj_at);
            i_start = inj; i_wr_en = inj; i_w_we = inj;
            i_wr_addr = 3'd0; i_wr_data = 4'(15 - in_m[0]);
            i_w_row = 3'd0; i_w_col = 1'b0; i_w_data = 4'(15 - w_m[0][0]);
            rst = (cnt == rst_at);
            tick();
        end
        i_start = 1'b0; i_wr_en = 1'b0; i_w_we = 1'b0; rst = 1'b0;
        if (rst_at > 0) begin
            check("busy_len_abort", cnt, rst_at);
            check("no_done_abort_s0", done0, 0);
            check("no_done_abort_s2", done2, 0);
            for (int c = 0; c < no; c++) begin
                ob_m[0][c] = 0;
                ob_m[1][c] = 0;
            end
        end else begin
            check("busy_len", cnt, no * (xs + 1));
            check("done_pulse_s0", done0, 1);
            check("done_pulse_s2", done2, 1);
            ob_m = nv;
            tick();
            check("done_one_cycle", done0, 0);
            check("busy_stays_low", busy0, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_w_we = 0; i_w_row = 0; i_w_col = 0; i_w_data = 0;
        i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0;
        i_start = 0; i_rd_addr = 0;
        for (int c = 0; c < no; c++) begin
            ob_m[0][c] = 0;
            ob_m[1][c] = 0;
        end

        // Reset state
        tick();
        tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rd", rd0, 0);
        check("rst_rd_s2", rd2, 0);
        rst = 1'b0;
        read_check(0);
        read_check(1);

        // All inputs 1, column 0 weights 1, column 1 weights 2
        for (int r = 0; r < xs; r++) begin
            write_in(r, 1);
            write_w(r, 0, 1);
            write_w(r, 1, 2);
        end
        run(0, 0, -1, -1);
        read_check(0);
        read_check(1);
        read_check(5);

        // Start and writes during busy cycle 3 are dropped
        run(3, 0, -1, -1);
        read_check(0);
        read_check(1);

        // Reset beats start and writes in the same cycle
        rst = 1'b1; i_start = 1'b1;
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 4'd0;
        i_w_we = 1'b1; i_w_row = 3'd0; i_w_col = 1'b0; i_w_data = 4'd0;
        tick();
        rst = 1'b0; i_start = 1'b0; i_wr_en = 1'b0; i_w_we = 1'b0;
        check("rst_prio_busy", busy0, 0);
        for (int c = 0; c < no; c++) begin
            ob_m[0][c] = 0;
            ob_m[1][c] = 0;
        end
        read_check(0);
        run(0, 0, -1, -1);
        read_check(0);
        read_check(1);

        // Zero inputs, random weights
        for (int r = 0; r < xs; r++) begin
            write_in(r, 0);
            write_w(r, 0, $urandom_range(0, 15));
            write_w(r, 1, $urandom_range(0, 15));
        end
        run(0, 0, -1, -1);
        read_check(0);
        read_check(1);
        read_check(5);

        // Single large product, then a small one written in the start cycle
        write_in(0, 15);
        write_w(0, 0, 15);
        run(0, 0, -1, -1);
        read_check(0);
        read_check(1);
        run(0, 0, 3, 3);
        read_check(0);
        read_check(1);

        // Abort with reset at busy cycle 10, then a clean rerun
        for (int r = 0; r < xs; r++) begin
            write_in(r, $urandom_range(0, 15));
            write_w(r, 0, $urandom_range(0, 15));
            write_w(r, 1, $urandom_range(0, 15));
        end
        run(0, 10, -1, -1);
        read_check(0);
        read_check(1);
        run(0, 0, -1, -1);
        read_check(0);
        read_check(1);

        // Random vectors; small inputs keep some results below saturation
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < xs; r++) begin
                write_in(r, $urandom_range(0, (k < 2) ? 1 : 15));
                write_w(r, 0, $urandom_range(0, (k < 2) ? 3 : 15));
                write_w(r, 1, $urandom_range(0, 15));
            end
            run(0, 0, -1, -1);
            for (int a = 0; a < xs; a++) read_check(a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
